// File: rtl/mips_pkg.sv
// Shared fetch-stage definitions: sequencer state encoding and address defaults.
package mips_pkg;

    localparam int MIPS_ADDR_W = 32;
    localparam int MIPS_PC_INC = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RUN    = 3'd1;
    localparam logic [2:0] S_STEP   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_HALTED = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_RUN    = S_RUN,
        ST_STEP   = S_STEP,
        ST_DRAIN  = S_DRAIN,
        ST_HALTED = S_HALTED
    } seq_state_e;

endpackage

// File: rtl/next_pc_mux.sv
// Next-address selector: branch beats jump beats sequential increment.
// The increment wraps modulo 2^ADDR_W.
module next_pc_mux
    import mips_pkg::*;
#(
    parameter int ADDR_W = MIPS_ADDR_W,
    parameter int PC_INC = MIPS_PC_INC
) (
    input  logic [ADDR_W-1:0] pc_value_i,
    input  logic              branch_taken_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic              jump_taken_i,
    input  logic [ADDR_W-1:0] jump_target_i,
    output logic [ADDR_W-1:0] next_addr_o,
    output logic              redirect_o
);

    // Priority select of the next fetch address.
    always_comb begin
        redirect_o = branch_taken_i | jump_taken_i;
        if (branch_taken_i) begin
            next_addr_o = branch_target_i;
        end else if (jump_taken_i) begin
            next_addr_o = jump_target_i;
        end else begin
            next_addr_o = pc_value_i + ADDR_W'(PC_INC);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: drives the PC load enable/address and provides
// run, single-step and halt-drain modes plus an executed-cycle counter.
module pc_sequencer
    import mips_pkg::*;
#(
    parameter int              ADDR_W      = MIPS_ADDR_W,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int              PC_INC      = MIPS_PC_INC,
    parameter int              DRAIN_DEPTH = 4,
    parameter int              CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step_req,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump_taken,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              halt_detected,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_enable,
    output logic [ADDR_W-1:0] pc_next,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int                DRAIN_W    = $clog2(DRAIN_DEPTH + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_DEPTH - 1);

    seq_state_e         state_q, state_d;
    logic               step_prev_q;
    logic               grant_q, grant_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic [ADDR_W-1:0]  mux_addr_s;
    logic               redirect_s;
    logic               step_rise_s;
    logic               count_en_s;

    next_pc_mux #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_next_pc_mux (
        .pc_value_i      (pc_value),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jump_taken_i    (jump_taken),
        .jump_target_i   (jump_target),
        .next_addr_o     (mux_addr_s),
        .redirect_o      (redirect_s)
    );

    // Next-state, PC enable and counter-enable decode.
    always_comb begin
        step_rise_s = step_req & ~step_prev_q;
        state_d     = state_q;
        grant_d     = grant_q;
        drain_d     = drain_q;
        pc_enable   = 1'b0;
        pc_next     = mux_addr_s;
        count_en_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                pc_next = RESET_ADDR;
                grant_d = 1'b0;
                if (start) begin
                    state_d = step_mode ? ST_STEP : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                pc_enable  = ~(stall & ~redirect_s);
                count_en_s = 1'b1;
                if (halt_detected) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_STEP: begin
                // A grant survives stalls; edges arriving while granted are dropped.
                pc_enable  = grant_q & ~(stall & ~redirect_s);
                count_en_s = pc_enable;
                if (grant_q) begin
                    grant_d = ~pc_enable;
                end else begin
                    grant_d = step_rise_s;
                end
                if (halt_detected) begin
                    state_d = ST_DRAIN;
                    drain_d = DRAIN_LOAD;
                    grant_d = 1'b0;
                end else begin
                    state_d = ST_STEP;
                end
            end
            ST_DRAIN: begin
                count_en_s = 1'b1;
                drain_d    = drain_q - DRAIN_W'(1);
                if (drain_q <= DRAIN_W'(1)) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 1'b0;
            end
        endcase

        if (count_en_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
        busy_d   = (state_d == ST_RUN) || (state_d == ST_STEP) || (state_d == ST_DRAIN);
        halted_d = (state_d == ST_HALTED);
    end

    // State, step edge detector, drain and cycle counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_prev_q <= 1'b0;
            grant_q     <= 1'b0;
            drain_q     <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_prev_q <= step_req;
            grant_q     <= grant_d;
            drain_q     <= drain_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
        end
    end

    assign busy        = busy_q;
    assign halted      = halted_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed tables, hand sequences and
// randomized stimulus against a mode-level reference model.
module tb_pc_sequencer;

    localparam int DRAIN_DEPTH = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_DRAIN = 3, M_HALT = 4;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic [31:0] pc;
        logic        exp_en;
        logic [31:0] exp_next;
    } vec_t;

    typedef struct {
        logic sr;
        logic st;
        logic exp_en;
    } step_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, step_mode, step_req, stall, branch_taken, jump_taken, halt_detected;
    logic [31:0] branch_target, jump_target, pc_value;
    logic        pc_enable, busy, halted;
    logic [31:0] pc_next, cycle_count;
    logic        pc_enable_s4, busy_s4, halted_s4;
    logic [31:0] pc_next_s4;
    logic [3:0]  cycle_count_s4;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int              m_mode;
    bit              m_grant, m_prev;
    int              m_drain;
    longint unsigned m_cnt;
    logic [31:0]     m_pc;
    bit              track_pc;

    logic        s_en, s_busy, s_halted;
    logic [31:0] s_next, s_cnt;

    always #5 clk = ~clk;

    pc_sequencer #(.DRAIN_DEPTH(DRAIN_DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step_req(step_req),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target), .halt_detected(halt_detected),
        .pc_value(pc_value), .pc_enable(pc_enable), .pc_next(pc_next), .busy(busy),
        .halted(halted), .cycle_count(cycle_count)
    );

    pc_sequencer #(.DRAIN_DEPTH(DRAIN_DEPTH), .CNT_W(4)) dut_s4 (
        .clk(clk), .reset(reset), .start(start), .step_mode(step_mode), .step_req(step_req),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_taken(jump_taken), .jump_target(jump_target), .halt_detected(halt_detected),
        .pc_value(pc_value), .pc_enable(pc_enable_s4), .pc_next(pc_next_s4), .busy(busy_s4),
        .halted(halted_s4), .cycle_count(cycle_count_s4)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_grant = 1'b0;
        m_prev  = 1'b0;
        m_drain = 0;
        m_cnt   = 0;
        m_pc    = 32'h0;
    endtask

    function automatic logic [31:0] exp_next_f();
        logic [31:0] t;
        if (branch_taken)     t = branch_target;
        else if (jump_taken)  t = jump_target;
        else                  t = pc_value + 32'd4;
        return (m_mode == M_IDLE) ? 32'h0 : t;
    endfunction

    function automatic logic exp_en_f();
        logic may_load;
        may_load = (m_mode == M_RUN) || (m_mode == M_STEP && m_grant);
        return may_load && !(stall && !(branch_taken || jump_taken));
    endfunction

    task automatic model_edge(input logic en, input logic [31:0] nx);
        bit rise;
        rise = step_req && !m_prev;
        if (m_mode == M_RUN || m_mode == M_DRAIN || (m_mode == M_STEP && en))
            if (m_cnt != 64'hFFFF_FFFF) m_cnt++;
        if (en) m_pc = nx;
        m_prev = step_req;
        case (m_mode)
            M_IDLE:  if (start) m_mode = step_mode ? M_STEP : M_RUN;
            M_RUN:   if (halt_detected) begin m_mode = M_DRAIN; m_drain = DRAIN_DEPTH - 1; end
            M_STEP: begin
                if (m_grant) m_grant = !en;
                else         m_grant = rise;
                if (halt_detected) begin m_mode = M_DRAIN; m_drain = DRAIN_DEPTH - 1; m_grant = 1'b0; end
            end
            M_DRAIN: begin
                m_drain--;
                if (m_drain <= 0) m_mode = M_HALT;
            end
            default: ;
        endcase
    endtask

    // One clock cycle: compare both DUTs with the model, then advance the model.
    task automatic tick();
        logic        exp_e;
        logic [31:0] exp_nx;
        longint unsigned sm;
        if (track_pc) pc_value = m_pc;
        #1;
        exp_e  = exp_en_f();
        exp_nx = exp_next_f();
        s_en = pc_enable; s_next = pc_next; s_busy = busy; s_halted = halted; s_cnt = cycle_count;
        chk("pc_enable", pc_enable, exp_e);
        chk("pc_next", pc_next, exp_nx);
        chk("busy", busy, (m_mode == M_RUN || m_mode == M_STEP || m_mode == M_DRAIN));
        chk("halted", halted, (m_mode == M_HALT));
        chk("cycle_count", cycle_count, m_cnt);
        sm = (m_cnt > 15) ? 15 : m_cnt;
        chk("cycle_count_sat4", cycle_count_s4, sm);
        chk("pc_enable_w4", pc_enable_s4, exp_e);
        chk("pc_next_w4", pc_next_s4, exp_nx);
        chk("status_w4", {busy_s4, halted_s4}, {busy, halted});
        @(posedge clk);
        model_edge(exp_e, exp_nx);
        @(negedge clk);
    endtask

    // Assert reset between clock edges and check outputs before any edge.
    task automatic async_reset_check();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        chk("arst_pc_enable", pc_enable, 1'b0);
        chk("arst_pc_next", pc_next, 32'h0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_halted", halted, 1'b0);
        chk("arst_cycle_count", cycle_count, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_inputs();
        start = 1'b0; step_mode = 1'b0; step_req = 1'b0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump_taken = 1'b0; jump_target = 32'h0;
        halt_detected = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[9];
        step_t steps[23];
        int    en_total;

        vecs[0] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h10,        1'b0, 32'h14};
        vecs[1] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   32'h10,        1'b0, 32'h14};
        vecs[2] = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   32'h10,        1'b1, 32'h40};
        vecs[3] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h200, 32'h40,        1'b1, 32'h100};
        vecs[4] = '{1'b0, 1'b0, 32'h100, 1'b1, 32'h200, 32'h100,       1'b1, 32'h200};
        vecs[5] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'hFFFF_FFFC, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h80,  32'h0,         1'b1, 32'h80};
        vecs[7] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   32'h200,       1'b1, 32'h204};
        vecs[8] = '{1'b1, 1'b1, 32'h300, 1'b1, 32'h400, 32'h80,        1'b1, 32'h300};

        // two pulses (second stalled), a 5-cycle hold, an edge dropped while granted
        steps[0]  = '{1'b0, 1'b0, 1'b0}; steps[1]  = '{1'b1, 1'b0, 1'b0};
        steps[2]  = '{1'b0, 1'b0, 1'b1}; steps[3]  = '{1'b0, 1'b0, 1'b0};
        steps[4]  = '{1'b1, 1'b0, 1'b0}; steps[5]  = '{1'b0, 1'b1, 1'b0};
        steps[6]  = '{1'b0, 1'b1, 1'b0}; steps[7]  = '{1'b0, 1'b0, 1'b1};
        steps[8]  = '{1'b0, 1'b0, 1'b0}; steps[9]  = '{1'b1, 1'b0, 1'b0};
        steps[10] = '{1'b1, 1'b0, 1'b1}; steps[11] = '{1'b1, 1'b0, 1'b0};
        steps[12] = '{1'b1, 1'b0, 1'b0}; steps[13] = '{1'b1, 1'b0, 1'b0};
        steps[14] = '{1'b0, 1'b0, 1'b0}; steps[15] = '{1'b0, 1'b0, 1'b0};
        steps[16] = '{1'b0, 1'b0, 1'b0}; steps[17] = '{1'b1, 1'b0, 1'b0};
        steps[18] = '{1'b0, 1'b1, 1'b0}; steps[19] = '{1'b1, 1'b1, 1'b0};
        steps[20] = '{1'b0, 1'b0, 1'b1}; steps[21] = '{1'b0, 1'b0, 1'b0};
        steps[22] = '{1'b0, 1'b0, 1'b0};

        clear_inputs();
        pc_value = 32'h0;
        track_pc = 1'b1;
        reset    = 1'b1;
        model_reset();
        start    = 1'b1;
        #1;
        chk("rst_pc_enable", pc_enable, 1'b0);
        chk("rst_pc_next", pc_next, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_cycle_count", cycle_count, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Free run from reset: 0, 4, 8, C, ...
        start = 1'b1;
        tick();
        chk("idle_next", s_next, 32'h0);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk("run_next", s_next, 32'(4 * i));
            chk("run_en", s_en, 1'b1);
        end
        #1;
        chk("count_after_4", cycle_count, 32'd4);

        // Directed selector/stall vectors in RUN
        track_pc = 1'b0;
        foreach (vecs[v]) begin
            stall = vecs[v].stall; branch_taken = vecs[v].br; branch_target = vecs[v].bt;
            jump_taken = vecs[v].jp; jump_target = vecs[v].jt; pc_value = vecs[v].pc;
            tick();
            chk("vec_en", s_en, vecs[v].exp_en);
            chk("vec_next", s_next, vecs[v].exp_next);
        end
        clear_inputs();

        // Halt together with a branch: redirect still loads, then drain
        pc_value = 32'h600;
        halt_detected = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
        tick();
        chk("halt_cycle_en", s_en, 1'b1);
        chk("halt_cycle_next", s_next, 32'h500);
        clear_inputs();
        for (int k = 1; k <= 3; k++) begin
            branch_taken = (k == 2);
            tick();
            chk("drain_en", s_en, 1'b0);
            chk("drain_busy", s_busy, 1'b1);
            chk("drain_halted", s_halted, 1'b0);
        end
        clear_inputs();
        tick();
        chk("halted_at_n4", s_halted, 1'b1);
        chk("halted_busy", s_busy, 1'b0);
        chk("halted_count", s_cnt, 32'd17);
        start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("halted_sticky", s_halted, 1'b1);
            chk("halted_en", s_en, 1'b0);
            chk("halted_frozen_count", s_cnt, 32'd17);
        end
        clear_inputs();

        // Async reset mid-drain, then fetch restarts at 0
        async_reset_check();
        track_pc = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        halt_detected = 1'b1; tick(); halt_detected = 1'b0;
        tick(); tick();
        async_reset_check();
        start = 1'b1; tick();
        chk("restart_idle_next", s_next, 32'h0);
        start = 1'b0; tick();
        chk("restart_next", s_next, 32'h4);
        chk("restart_en", s_en, 1'b1);

        // Single-step grants
        async_reset_check();
        step_mode = 1'b1; start = 1'b1; tick();
        start = 1'b0; step_mode = 1'b0;
        en_total = 0;
        foreach (steps[s]) begin
            step_req = steps[s].sr; stall = steps[s].st;
            tick();
            chk("step_en", s_en, steps[s].exp_en);
            if (s_en === 1'b1) en_total++;
        end
        chk("step_en_total", en_total, 4);
        clear_inputs();
        halt_detected = 1'b1; tick(); halt_detected = 1'b0;
        tick();

        // Randomized traffic against the model
        async_reset_check();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(299) == 0) async_reset_check();
            if (m_mode == M_HALT && $urandom_range(7) == 0) async_reset_check();
            start         = ($urandom_range(3) == 0);
            step_mode     = 1'($urandom_range(1));
            step_req      = ($urandom_range(2) == 0);
            stall         = ($urandom_range(3) == 0);
            branch_taken  = ($urandom_range(7) == 0);
            branch_target = $urandom() & 32'hFFFF_FFFC;
            jump_taken    = ($urandom_range(7) == 0);
            jump_target   = $urandom() & 32'hFFFF_FFFC;
            halt_detected = ($urandom_range(40) == 0);
            track_pc      = ($urandom_range(15) != 0);
            if (!track_pc) pc_value = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : $urandom();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
